// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: operand width,
// iteration count, request opcode encodings and FSM state encodings.
// Pure declarations; no latency or backpressure of its own.
package muldiv_unit_pkg;

    localparam int XLEN  = 32;             // operand/HI/LO width; only 32 is supported
    localparam int ITER  = 32;             // iterations per mult/div; must equal XLEN
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Two's-complement negate when sgn is set; used both for taking operand
    // magnitudes and for restoring result signs.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic sgn);
        return sgn ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage (master) and muldiv_unit (slave).
// Ports: req_valid/req_op/req_a/req_b from master; req_ready/busy/done/hi/lo to master.
// Backpressure: master holds its request while req_ready is low.
interface muldiv_unit_if;

    logic                               req_valid;
    logic [2:0]                         req_op;
    logic [muldiv_unit_pkg::XLEN-1:0]   req_a;
    logic [muldiv_unit_pkg::XLEN-1:0]   req_b;
    logic                               req_ready;
    logic                               busy;
    logic                               done;
    logic [muldiv_unit_pkg::XLEN-1:0]   hi;
    logic [muldiv_unit_pkg::XLEN-1:0]   lo;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, busy, done, hi, lo
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_unit_shift_core.sv
// md_shift_core: 64-bit iterative datapath, one radix-2 shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle while step_i is high.
// Ports: load_i/acc_init_i/opnd_i seed the accumulator and operand; acc_o is the raw accumulator.
// No handshake: the caller sequences load and exactly ITER steps.
module md_shift_core
    import muldiv_unit_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                load_i,
    input  logic [2*XLEN-1:0]   acc_init_i,
    input  logic [XLEN-1:0]     opnd_i,
    input  logic                step_i,
    input  logic                div_mode_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q;

    // Multiply: acc = {partial_hi, multiplier}; add multiplicand into the upper
    // half when the multiplier LSB is set, then shift the whole thing right.
    logic [XLEN:0]     mul_sum;
    // Divide: acc = {remainder, dividend/quotient}; shift one dividend bit into
    // the remainder, subtract the divisor if it fits, shift the quotient bit in.
    logic [XLEN:0]     div_rem;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge   = (div_rem >= {1'b0, opnd_q});
        // When the subtraction succeeds the true difference is below the divisor,
        // so the modulo-2^XLEN difference of the low bits is exact.
        div_diff = div_rem[XLEN-1:0] - opnd_q;

        acc_d = acc_q;
        if (div_mode_i) begin
            if (div_ge)
                acc_d = {div_diff, acc_q[XLEN-2:0], 1'b1};
            else
                acc_d = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else if (load_i) begin
            acc_q  <= acc_init_i;
            opnd_q <= opnd_i;
        end else if (step_i) begin
            acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide responder; FSM, sign handling and HI/LO registers.
// Latency: mult/div accepted at edge E0 writes HI/LO at E0+33 (busy for 33 cycles, done pulses after);
// MTHI/MTLO write on the accept edge. Backpressure: req_ready = ~busy, requests held by the master.
// Ports: CLK, RST (async active-high), md (slave side of muldiv_unit_if).
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    muldiv_unit_if.slave    md
);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    hi_q, lo_q;
    logic               busy_q, done_q;
    logic               is_div_q;
    logic               neg_lo_q;       // product sign (mult) or quotient sign (div)
    logic               neg_hi_q;       // remainder sign; follows the dividend
    logic               div0_q;
    logic [XLEN-1:0]    a_raw_q;        // dividend as presented, returned in HI on divide-by-zero

    md_op_e             op;
    logic               accept;
    logic               is_mul_op, is_div_op, signed_op;
    logic               sgn_a, sgn_b;
    logic [XLEN-1:0]    mag_a, mag_b;

    logic               core_load;
    logic [2*XLEN-1:0]  core_init;
    logic [XLEN-1:0]    core_opnd;
    logic [2*XLEN-1:0]  core_acc;

    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    hi_d, lo_d;

    always_comb begin
        op        = md_op_e'(md.req_op);
        accept    = md.req_valid && !busy_q;
        is_mul_op = (op == MD_MULT) || (op == MD_MULTU);
        is_div_op = (op == MD_DIV)  || (op == MD_DIVU);
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        sgn_a     = signed_op && md.req_a[XLEN-1];
        sgn_b     = signed_op && md.req_b[XLEN-1];
        mag_a     = cond_neg(md.req_a, sgn_a);
        mag_b     = cond_neg(md.req_b, sgn_b);

        core_load = accept && (is_mul_op || is_div_op);
        // Multiply seeds the accumulator with the multiplier and adds the
        // multiplicand; divide seeds it with the dividend and subtracts the divisor.
        core_init = {{XLEN{1'b0}}, (is_div_op ? mag_a : mag_b)};
        core_opnd = is_div_op ? mag_b : mag_a;
    end

    md_shift_core u_core (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (core_load),
        .acc_init_i (core_init),
        .opnd_i     (core_opnd),
        .step_i     ((state_q == ST_MUL) || (state_q == ST_DIV)),
        .div_mode_i (state_q == ST_DIV),
        .acc_o      (core_acc)
    );

    // Sign fix-up applied in the FIX cycle.
    always_comb begin
        prod_fix = neg_lo_q ? (~core_acc + (2*XLEN)'(1)) : core_acc;
        hi_d     = prod_fix[2*XLEN-1:XLEN];
        lo_d     = prod_fix[XLEN-1:0];
        if (is_div_q) begin
            if (div0_q) begin
                hi_d = a_raw_q;
                lo_d = '1;
            end else begin
                hi_d = cond_neg(core_acc[2*XLEN-1:XLEN], neg_hi_q);
                lo_d = cond_neg(core_acc[XLEN-1:0], neg_lo_q);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            a_raw_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            MD_MTHI: hi_q <= md.req_a;
                            MD_MTLO: lo_q <= md.req_a;
                            MD_MULT, MD_MULTU: begin
                                state_q  <= ST_MUL;
                                busy_q   <= 1'b1;
                                cnt_q    <= '0;
                                is_div_q <= 1'b0;
                                neg_lo_q <= sgn_a ^ sgn_b;
                                neg_hi_q <= 1'b0;
                                div0_q   <= 1'b0;
                            end
                            MD_DIV, MD_DIVU: begin
                                state_q  <= ST_DIV;
                                busy_q   <= 1'b1;
                                cnt_q    <= '0;
                                is_div_q <= 1'b1;
                                neg_lo_q <= sgn_a ^ sgn_b;
                                neg_hi_q <= sgn_a;
                                div0_q   <= (md.req_b == '0);
                                a_raw_q  <= md.req_a;
                            end
                            default: ;  // ops 6/7 are accepted and dropped
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign md.req_ready = ~busy_q;
    assign md.busy      = busy_q;
    assign md.done      = done_q;
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle HI/LO multiply/divide responder for the execute stage.
- The execute stage acts as initiator: it issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests over a valid/ready handshake and reads HI/LO for MFHI/MFLO.
- The unit replaces single-cycle HI/LO arithmetic with a 32-iteration radix-2 shift-add multiplier and a restoring divider.
- The execute stage must stall MFHI/MFLO, and any new request, while busy is high.

Parameters:
- XLEN, 32, operand/HI/LO width. Only 32 is supported; exists for readability.
- ITER, 32, iterations per mult/div. Must equal XLEN.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6,7 are no-op.
- req_a  in  XLEN  rs operand (Rdata1).
- req_b  in  XLEN  rt operand (Rdata2).
- req_ready  out  1  = ~busy.
- busy  out  1  mult/div in progress.
- done  out  1  one-cycle pulse when HI/LO written by a mult/div.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State returns to IDLE.
  - hi=0, lo=0, busy=0, done=0, iteration counter=0.
  - Any in-flight result is discarded.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. If req_valid && !req_ready, the unit takes no action; the initiator must hold the request.
- MTHI/MTLO:
  - Write hi or lo with req_a on the accept edge.
  - The other register is unchanged; busy stays 0; done stays 0.
- Ops 6/7: accepted and ignored.
- MULT/MULTU/DIV/DIVU acceptance:
  - Latch operands.
  - Signed ops latch magnitudes and the result signs: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Unsigned ops use the raw operands with both signs = 0.
  - busy rises on the accept edge.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL or DIV on an accepted mult/div.
  - MUL/DIV run exactly ITER cycles, counter 0..31, then go to FIX.
  - FIX takes 1 cycle: conditional two's-complement negation, then writes {hi,lo}, then goes to IDLE.
- Timing:
  - Accept at edge E0 -> hi/lo valid and busy=0 after edge E0+33.
  - done=1 for exactly the cycle following E0+33.
  - A new request may be accepted at edge E0+33 + 1 (first edge with ready=1).
- MUL: 64-bit accumulator, shift-add of the multiplicand gated by the multiplier LSB each iteration. Result: hi = product[63:32], lo = product[31:0].
- DIV:
  - Restoring; one quotient bit per iteration, MSB first.
  - lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
- Divide by zero (both DIV and DIVU):
  - lo = 32'hFFFFFFFF, hi = req_a as originally presented.
  - No sign fix is applied; still takes the full 33 cycles.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- hi/lo are stable at all times except on a write edge; no partial results are visible.

Decomposition:
- Op encodings (MD_MULT..MD_MTLO) and FSM state constants go in the shared common_param.vh header, alongside the funct/opcode constants, so the execute stage can map funct codes to req_op.
- One sub-module is natural: md_shift_core, which holds the 64-bit iterative datapath (shift-add / restoring-subtract step, selected by a mode bit). The FSM, sign handling and HI/LO live in muldiv_unit.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse 1 cycle, busy high exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands as MULT -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- MTHI 0xAAAA5555 while idle -> hi updates the next edge, lo unchanged, no busy/done. MTLO during a MULT (req_valid held) -> req_ready=0, not applied until after done; then lo=the MTLO value.
- Assert RST at cycle 10 of a DIV -> hi, lo, busy, done go to 0 immediately without a clock edge. After release, a fresh MULT 6*7 -> lo=42, hi=0.
